collision_detector: RTL and testbench
=====================================

COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 Parameter P1_X, default 64: x coordinate of the player-1 (left) paddle face.
REQ-002 Parameter CPU_X, default 576: x coordinate of the CPU (right) paddle face.
REQ-003 Parameter PADDLE_W, default 8: paddle thickness in pixels along x.
REQ-004 Parameter PADDLE_H, default 64: paddle height in pixels along y.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 ball_posx  input  10  ball x position in pixels.
REQ-008 ball_posy  input  10  ball y position in pixels.
REQ-009 p1_posy  input  10  top y of the player-1 paddle.
REQ-010 cpu_posy  input  10  top y of the CPU paddle.
REQ-011 ball_x_vel  input  1  ball horizontal direction: 0 = moving left (toward P1), 1 = moving right (toward CPU).
REQ-012 collision  output  1  registered: ball overlaps a paddle.
REQ-013 hit_p1  output  1  registered: the overlap is with the P1 paddle.
REQ-014 hit_cpu  output  1  registered: the overlap is with the CPU paddle.

Function
REQ-015 p1_x_ok SHALL be true when P1_X-PADDLE_W <= ball_posx <= P1_X, inclusive.
REQ-016 cpu_x_ok SHALL be true when CPU_X <= ball_posx <= CPU_X+PADDLE_W, inclusive.
REQ-017 p1_y_ok SHALL be true when p1_posy <= ball_posy <= p1_posy+PADDLE_H, inclusive; the same rule applies to cpu_y_ok using cpu_posy.
REQ-018 All sums SHALL be computed 11 bits wide with no wrap, so a paddle whose top is near 1023 never matches a small ball_posy.
REQ-019 If P1_X < PADDLE_W, the lower x bound SHALL clamp to 0 with no underflow.
REQ-020 Combinational hit_p1_c SHALL equal p1_x_ok AND p1_y_ok, and hit_cpu_c SHALL equal cpu_x_ok AND cpu_y_ok, each qualified by direction per REQ-025.
REQ-021 On each rising clk edge, hit_p1 SHALL load hit_p1_c, hit_cpu SHALL load hit_cpu_c, and collision SHALL load hit_p1_c OR hit_cpu_c.
REQ-022 Latency SHALL be exactly 1 clock from an input change to the output change, with no handshake.
REQ-023 Outputs SHALL be levels that stay asserted every cycle the overlap persists.
REQ-024 If parameters make both windows match at once, hit_p1 and hit_cpu SHALL both assert and collision SHALL assert.

Configuration
REQ-025 With macro COLLISION_DIR_GATE_EN defined, hit_p1_c SHALL additionally require ball_x_vel=0 and hit_cpu_c SHALL additionally require ball_x_vel=1; without it, ball_x_vel SHALL be ignored and the port kept.

Reset
REQ-026 While rst_n=0, collision, hit_p1 and hit_cpu SHALL be 0 immediately, independent of clk.
REQ-027 Assertion of rst_n mid-operation SHALL clear all outputs at once.
REQ-028 The first rising edge after rst_n rises SHALL register the current inputs normally.

Verification
REQ-029 Ball at (320,240), p1_posy=80, cpu_posy=240, vel=0 -> collision=0, hit_p1=0, hit_cpu=0 one clock later.
REQ-030 Ball at (64,240), p1_posy=240, vel=0 -> collision=1, hit_p1=1; then ball_posy=0, p1_posy=400 -> collision=0.
REQ-031 Ball at (576,240), cpu_posy=240, vel=1 -> collision=1, hit_cpu=1; same inputs with vel=0 -> collision=1 without COLLISION_DIR_GATE_EN and collision=0 with it.
REQ-032 Boundaries with p1_posy=100, ball_posx=64: ball_posy 100 and 164 -> collision=1; 99 and 165 -> 0; ball_posx 56 -> 1; ball_posx 55 -> 0.
REQ-033 Wrap check: cpu_posy=1000, ball_posy=10, ball_posx=576 -> collision=0.
REQ-034 Reset while collision=1: drop rst_n between clock edges -> all outputs 0 immediately; release rst_n -> the next edge restores collision=1.

Source files
------------

// File: rtl/collision_detector.sv
// Pong ball/paddle overlap detector; optional macro COLLISION_DIR_GATE_EN gates each hit by ball direction.
// Latency: 1 clk from inputs to registered level outputs. Backpressure: none, evaluated every cycle.
// Windows are inclusive on both ends; all bounds are 11-bit so paddle bottoms never wrap.
module collision_detector #(
  parameter int P1_X     = 64,
  parameter int CPU_X    = 576,
  parameter int PADDLE_W = 8,
  parameter int PADDLE_H = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] ball_posx,
  input  logic [9:0] ball_posy,
  input  logic [9:0] p1_posy,
  input  logic [9:0] cpu_posy,
  input  logic       ball_x_vel,
  output logic       collision,
  output logic       hit_p1,
  output logic       hit_cpu
);

  // Left paddle lower x bound clamps at 0 rather than underflowing.
  localparam int          P1_LO_I = (P1_X >= PADDLE_W) ? (P1_X - PADDLE_W) : 0;
  localparam logic [10:0] P1_LO   = 11'(P1_LO_I);
  localparam logic [10:0] P1_HI   = 11'(P1_X);
  localparam logic [10:0] CPU_LO  = 11'(CPU_X);
  localparam logic [10:0] CPU_HI  = 11'(CPU_X + PADDLE_W);
  localparam logic [10:0] PAD_H   = 11'(PADDLE_H);

  logic [10:0] bx, by, p1_top, p1_bot, cpu_top, cpu_bot;
  logic        p1_x_ok, cpu_x_ok, p1_y_ok, cpu_y_ok;
  logic        hit_p1_c, hit_cpu_c;

  assign bx      = {1'b0, ball_posx};
  assign by      = {1'b0, ball_posy};
  assign p1_top  = {1'b0, p1_posy};
  assign cpu_top = {1'b0, cpu_posy};
  assign p1_bot  = p1_top + PAD_H;
  assign cpu_bot = cpu_top + PAD_H;

  assign p1_x_ok  = (bx >= P1_LO) && (bx <= P1_HI);
  assign cpu_x_ok = (bx >= CPU_LO) && (bx <= CPU_HI);
  assign p1_y_ok  = (by >= p1_top) && (by <= p1_bot);
  assign cpu_y_ok = (by >= cpu_top) && (by <= cpu_bot);

`ifdef COLLISION_DIR_GATE_EN
  assign hit_p1_c  = p1_x_ok && p1_y_ok && !ball_x_vel;
  assign hit_cpu_c = cpu_x_ok && cpu_y_ok && ball_x_vel;
`else
  logic unused_vel;
  assign unused_vel = ball_x_vel;
  assign hit_p1_c  = p1_x_ok && p1_y_ok;
  assign hit_cpu_c = cpu_x_ok && cpu_y_ok;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision <= 1'b0;
      hit_p1    <= 1'b0;
      hit_cpu   <= 1'b0;
    end else begin
      collision <= hit_p1_c || hit_cpu_c;
      hit_p1    <= hit_p1_c;
      hit_cpu   <= hit_cpu_c;
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Bench for collision_detector: directed table, reset sequences, random vs. reference model.
module tb_collision_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] ball_posx = '0, ball_posy = '0, p1_posy = '0, cpu_posy = '0;
  logic       ball_x_vel = 1'b0;
  logic       collision, hit_p1, hit_cpu;
  logic       collision2, hit_p12, hit_cpu2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  collision_detector dut (
    .clk(clk), .rst_n(rst_n), .ball_posx(ball_posx), .ball_posy(ball_posy),
    .p1_posy(p1_posy), .cpu_posy(cpu_posy), .ball_x_vel(ball_x_vel),
    .collision(collision), .hit_p1(hit_p1), .hit_cpu(hit_cpu)
  );

  // Overlapping windows (P1 0..4 clamped, CPU 0..8) exercise the clamp and double hits.
  collision_detector #(.P1_X(4), .CPU_X(0), .PADDLE_W(8), .PADDLE_H(64)) dut2 (
    .clk(clk), .rst_n(rst_n), .ball_posx(ball_posx), .ball_posy(ball_posy),
    .p1_posy(p1_posy), .cpu_posy(cpu_posy), .ball_x_vel(ball_x_vel),
    .collision(collision2), .hit_p1(hit_p12), .hit_cpu(hit_cpu2)
  );

  // Returns {collision, hit_p1, hit_cpu} straight from the geometric rules.
  function automatic logic [2:0] model(int p1x, int cpux, int w, int h,
                                       int bx, int by, int p1y, int cpuy, int vel);
    int lo;
    bit hp, hc;
    lo = p1x - w;
    if (lo < 0) lo = 0;
    hp = (bx >= lo) && (bx <= p1x) && (by >= p1y) && (by <= p1y + h);
    hc = (bx >= cpux) && (bx <= cpux + w) && (by >= cpuy) && (by <= cpuy + h);
`ifdef COLLISION_DIR_GATE_EN
    hp = hp && (vel == 0);
    hc = hc && (vel == 1);
`endif
    return {hp | hc, hp, hc};
  endfunction

  task automatic check3(string name, logic [2:0] act, logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {col,p1,cpu}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(int bx, int by, int p1y, int cpuy, int vel);
    ball_posx  = 10'(bx);
    ball_posy  = 10'(by);
    p1_posy    = 10'(p1y);
    cpu_posy   = 10'(cpuy);
    ball_x_vel = vel[0];
  endtask

  // Drive, take one rising edge, sample 1 time unit later; dut2 is always checked against the model.
  task automatic apply(int bx, int by, int p1y, int cpuy, int vel);
    drive(bx, by, p1y, cpuy, vel);
    @(posedge clk);
    #1;
    check3("dut2_model", {collision2, hit_p12, hit_cpu2},
           model(4, 0, 8, 64, bx, by, p1y, cpuy, vel));
  endtask

  typedef struct {
    string      name;
    int         bx, by, p1y, cpuy, vel;
    logic [2:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [2:0] gated_exp;
`ifdef COLLISION_DIR_GATE_EN
    gated_exp = 3'b000;
`else
    gated_exp = 3'b101;
`endif
    tbl.push_back('{"center_miss",   320, 240,  80,  240, 0, 3'b000});
    tbl.push_back('{"p1_hit",         64, 240, 240,    0, 0, 3'b110});
    tbl.push_back('{"p1_miss_y",      64,   0, 400,    0, 0, 3'b000});
    tbl.push_back('{"cpu_hit",       576, 240,   0,  240, 1, 3'b101});
    tbl.push_back('{"cpu_wrong_dir", 576, 240,   0,  240, 0, gated_exp});
    tbl.push_back('{"p1_y_top",       64, 100, 100,    0, 0, 3'b110});
    tbl.push_back('{"p1_y_bot",       64, 164, 100,    0, 0, 3'b110});
    tbl.push_back('{"p1_y_above",     64,  99, 100,    0, 0, 3'b000});
    tbl.push_back('{"p1_y_below",     64, 165, 100,    0, 0, 3'b000});
    tbl.push_back('{"p1_x_lo",        56, 130, 100,    0, 0, 3'b110});
    tbl.push_back('{"p1_x_out",       55, 130, 100,    0, 0, 3'b000});
    tbl.push_back('{"p1_x_hi_out",    65, 130, 100,    0, 0, 3'b000});
    tbl.push_back('{"cpu_wrap",      576,  10,   0, 1000, 1, 3'b000});
    tbl.push_back('{"cpu_x_hi",      584, 300,   0,  250, 1, 3'b101});
    tbl.push_back('{"cpu_x_out_hi",  585, 300,   0,  250, 1, 3'b000});
    tbl.push_back('{"cpu_x_out_lo",  575, 300,   0,  250, 1, 3'b000});
    tbl.push_back('{"p1_wrap",        60,   5, 1000,   0, 0, 3'b000});
    tbl.push_back('{"p1_bottom_max",  60, 1023, 960,   0, 0, 3'b110});

    // Reset state, held across clock edges.
    drive(64, 240, 240, 0, 0);
    #2;
    check3("reset_async", {collision, hit_p1, hit_cpu}, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check3("reset_held", {collision, hit_p1, hit_cpu}, 3'b000);
    // First edge after release registers the inputs normally.
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check3("first_edge", {collision, hit_p1, hit_cpu}, 3'b110);

    foreach (tbl[i]) begin
      apply(tbl[i].bx, tbl[i].by, tbl[i].p1y, tbl[i].cpuy, tbl[i].vel);
      check3(tbl[i].name, {collision, hit_p1, hit_cpu}, tbl[i].exp);
    end

    // Level output persists while overlap persists.
    apply(64, 240, 240, 0, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check3("persist", {collision, hit_p1, hit_cpu}, 3'b110);
    end

    // Exactly one cycle of latency: output holds until the edge after an input change.
    drive(320, 240, 80, 240, 0);
    #2;
    check3("latency_hold", {collision, hit_p1, hit_cpu}, 3'b110);
    @(posedge clk);
    #1;
    check3("latency_update", {collision, hit_p1, hit_cpu}, 3'b000);

    // Mid-operation reset between edges clears at once; next edge restores.
    apply(64, 240, 240, 0, 0);
    check3("pre_reset", {collision, hit_p1, hit_cpu}, 3'b110);
    #1 rst_n = 1'b0;
    #1;
    check3("mid_reset", {collision, hit_p1, hit_cpu}, 3'b000);
    check3("mid_reset2", {collision2, hit_p12, hit_cpu2}, 3'b000);
    #1 rst_n = 1'b1;
    #1;
    check3("post_release", {collision, hit_p1, hit_cpu}, 3'b000);
    @(posedge clk);
    #1;
    check3("restore", {collision, hit_p1, hit_cpu}, 3'b110);

    // Double hit and clamp on the overlapping-window instance.
    apply(2, 50, 20, 40, 0);
    apply(2, 50, 20, 40, 1);
    apply(0, 30, 30, 0, 0);

    // Randomized, biased toward paddle edges.
    for (int i = 0; i < 400; i++) begin
      int bx, by, p1y, cpuy, vel;
      p1y  = $urandom_range(0, 1023);
      cpuy = $urandom_range(0, 1023);
      vel  = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: bx = $urandom_range(0, 1023);
        1: bx = $urandom_range(50, 70);
        2: bx = $urandom_range(570, 590);
        default: bx = $urandom_range(0, 12);
      endcase
      case ($urandom_range(0, 2))
        0: by = $urandom_range(0, 1023);
        1: by = p1y + $urandom_range(0, 70) - 3;
        default: by = cpuy + $urandom_range(0, 70) - 3;
      endcase
      if (by < 0) by = 0;
      if (by > 1023) by = 1023;
      apply(bx, by, p1y, cpuy, vel);
      check3("random", {collision, hit_p1, hit_cpu},
             model(64, 576, 8, 64, bx, by, p1y, cpuy, vel));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
